// File: rtl/video_ts_render_if.sv
// Renderer bus: task from the TSU, DRAM graphics fetch port and TS line-buffer write port.
// master is the surrounding system, slave is the renderer.
interface video_ts_render_if;
    logic        tsr_go;
    logic [5:0]  tsr_addr;
    logic [8:0]  tsr_line;
    logic [7:0]  tsr_page;
    logic [8:0]  tsr_x;
    logic [2:0]  tsr_xs;
    logic        tsr_xf;
    logic [3:0]  tsr_pal;
    logic        tsr_rdy;
    logic [20:0] dram_addr;
    logic        dram_req;
    logic        dram_next;
    logic [15:0] dram_rdata;
    logic        lb_we;
    logic [8:0]  lb_addr;
    logic [7:0]  lb_data;

    modport master (
        output tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
        output dram_next, dram_rdata,
        input  tsr_rdy, dram_addr, dram_req, lb_we, lb_addr, lb_data
    );

    modport slave (
        input  tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
        input  dram_next, dram_rdata,
        output tsr_rdy, dram_addr, dram_req, lb_we, lb_addr, lb_data
    );
endinterface

// File: rtl/video_ts_render.sv
// Tile/sprite renderer: fetches 4bpp graphics words, serialises 1 px/clk and writes
// opaque pixels tagged with the palette into the TS line buffer.
module video_ts_render #(
    parameter int LINE_PIX = 360
) (
    input logic             clk,
    input logic             res,
    video_ts_render_if.slave bus
);
    localparam logic [8:0] LINE_LIM = 9'(LINE_PIX);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nxt;

    logic [13:0] base;
    logic [6:0]  col;
    logic [4:0]  words_left;
    logic        xf;
    logic [3:0]  pal;
    logic [8:0]  pix_x;
    logic [15:0] hold;
    logic        hold_full;
    logic [15:0] sr;
    logic [1:0]  sr_left;
    logic        req;
    logic        accept, dram_ack, emit_sr, emit_ld;
    logic [3:0]  pix;

    assign accept   = bus.tsr_go && (state == IDLE);
    assign dram_ack = req && bus.dram_next;
    // The serialiser drains its own shift register first, then reloads from the holding buffer.
    assign emit_sr  = (sr_left != 2'd0);
    assign emit_ld  = (sr_left == 2'd0) && hold_full;
    assign pix      = emit_sr ? sr[15:12] : hold[15:12];

    always_comb begin
        state_nxt     = state;
        req           = 1'b0;
        bus.tsr_rdy   = 1'b0;
        case (state)
            IDLE: begin
                bus.tsr_rdy = 1'b1;
                if (bus.tsr_go) state_nxt = FETCH;
            end
            FETCH: begin
                req = !hold_full;
                if (dram_ack && words_left == 5'd1) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Nothing left to emit: the pixel now on lb_* is the last one.
                if (!hold_full && !emit_sr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bus.dram_req  = req;
        bus.dram_addr = {base, col};
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            base        <= '0;
            col         <= '0;
            words_left  <= '0;
            xf          <= 1'b0;
            pal         <= '0;
            pix_x       <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            sr          <= '0;
            sr_left     <= '0;
            bus.lb_we   <= 1'b0;
            bus.lb_addr <= '0;
            bus.lb_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                base       <= {bus.tsr_page + {5'b0, bus.tsr_line[8:6]}, bus.tsr_line[5:0]};
                // X-flip walks the columns backwards starting from the last word.
                col        <= {bus.tsr_addr, 1'b0} + (bus.tsr_xf ? {3'b0, bus.tsr_xs, 1'b1} : 7'd0);
                words_left <= {({1'b0, bus.tsr_xs} + 4'd1), 1'b0};
                xf         <= bus.tsr_xf;
                pal        <= bus.tsr_pal;
                pix_x      <= bus.tsr_x;
            end
            if (dram_ack) begin
                // Store nibbles in emission order, first pixel in [15:12].
                hold       <= xf ? {bus.dram_rdata[11:8], bus.dram_rdata[15:12],
                                    bus.dram_rdata[3:0],  bus.dram_rdata[7:4]}
                                 : {bus.dram_rdata[7:0],  bus.dram_rdata[15:8]};
                hold_full  <= 1'b1;
                words_left <= words_left - 5'd1;
                col        <= xf ? col - 7'd1 : col + 7'd1;
            end
            if (emit_ld) begin
                hold_full <= 1'b0;
                sr        <= {hold[11:0], 4'h0};
                sr_left   <= 2'd3;
            end else if (emit_sr) begin
                sr        <= {sr[11:0], 4'h0};
                sr_left   <= sr_left - 2'd1;
            end
            if (emit_ld || emit_sr) begin
                bus.lb_we   <= (pix != 4'h0) && (pix_x < LINE_LIM);
                bus.lb_addr <= pix_x;
                bus.lb_data <= {pal, pix};
                pix_x       <= pix_x + 9'd1;
            end else begin
                bus.lb_we   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_video_ts_render.sv
// Directed bench for video_ts_render: DRAM responder and line-buffer recorder run in the
// background, the main sequence issues tasks and compares recorded traffic.
module tb_video_ts_render;
    logic clk, res;
    int   vectors = 0, miscompares = 0;
    int   cyc = 0;
    int   data_mode = 0;
    bit   stall_en = 0;
    int   acc_addr[$], acc_cyc[$], wr_addr[$], wr_data[$], wr_cyc[$];

    video_ts_render_if bus();
    video_ts_render #(.LINE_PIX(360)) dut (.clk(clk), .res(res), .bus(bus));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial forever @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem(input logic [20:0] a);
        logic [15:0] w;
        case (data_mode)
            0:       w = (a[6:0] == 7'd10) ? 16'h2301 : (a[6:0] == 7'd11) ? 16'h0567 : 16'h0000;
            1:       w = 16'hFFFF;
            default: w = {4{a[3:0] | 4'h8}};
        endcase
        return w;
    endfunction

    // DRAM responder and line-buffer recorder, all sampled on the falling edge.
    initial begin
        bit nxt, prev_acc, prev_req;
        logic [20:0] prev_addr;
        prev_acc = 0; prev_req = 0; prev_addr = '0;
        bus.dram_next = 0; bus.dram_rdata = '0;
        forever begin
            @(negedge clk);
            if (prev_acc) chk("req_hold_full", 32'(bus.dram_req), 0);
            if (prev_req && !prev_acc && bus.dram_req)
                chk("addr_stable", 32'(bus.dram_addr), 32'(prev_addr));
            if (bus.lb_we === 1'b1) begin
                wr_addr.push_back(int'(bus.lb_addr));
                wr_data.push_back(int'(bus.lb_data));
                wr_cyc.push_back(cyc);
            end
            nxt = stall_en ? ($urandom_range(0, 2) == 0) : (bus.dram_req === 1'b1);
            bus.dram_next  = nxt;
            bus.dram_rdata = (bus.dram_req === 1'b1) ? mem(bus.dram_addr) : 16'($urandom);
            prev_acc = nxt && (bus.dram_req === 1'b1);
            if (prev_acc) begin
                acc_addr.push_back(int'(bus.dram_addr));
                acc_cyc.push_back(cyc);
            end
            prev_req  = (bus.dram_req === 1'b1);
            prev_addr = bus.dram_addr;
        end
    end

    task automatic clr();
        acc_addr.delete(); acc_cyc.delete();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    endtask

    task automatic set_task(input int addr, input int line, input int page, input int x,
                            input int xs, input int xf, input int pal);
        bus.tsr_addr = 6'(addr); bus.tsr_line = 9'(line); bus.tsr_page = 8'(page);
        bus.tsr_x = 9'(x); bus.tsr_xs = 3'(xs); bus.tsr_xf = 1'(xf); bus.tsr_pal = 4'(pal);
    endtask

    task automatic issue(input int addr, input int line, input int page, input int x,
                         input int xs, input int xf, input int pal);
        @(negedge clk);
        set_task(addr, line, page, x, xs, xf, pal);
        bus.tsr_go = 1;
        @(negedge clk);
        bus.tsr_go = 0;
        chk("rdy_busy", 32'(bus.tsr_rdy), 0);
    endtask

    task automatic wait_rdy(output int rc);
        rc = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.tsr_rdy === 1'b1) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) chk("rdy_timeout", 0, 1);
    endtask

    task automatic chk_tile(input string tag, input int ea[6], input int ed[6]);
        chk({tag, "_nwr"}, wr_addr.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr.size()) begin
                chk({tag, "_addr"}, wr_addr[i], ea[i]);
                chk({tag, "_data"}, wr_data[i], ed[i]);
            end
        end
    endtask

    initial begin
        int rc;
        int a10, a11;
        int t1a[6] = '{17, 18, 19, 20, 21, 23};
        int t1d[6] = '{'h31, 'h32, 'h33, 'h36, 'h37, 'h35};
        int t2a[6] = '{16, 18, 19, 20, 21, 22};
        int t2d[6] = '{'h35, 'h37, 'h36, 'h33, 'h32, 'h31};
        int b2a[6] = '{41, 42, 43, 44, 45, 47};
        a10 = ('h23 << 13) | (3 << 7) | 10;
        a11 = ('h23 << 13) | (3 << 7) | 11;
        bus.tsr_go = 0;
        set_task(0, 0, 0, 0, 0, 0, 0);
        res = 1;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(bus.tsr_rdy), 1);
        chk("rst_req", 32'(bus.dram_req), 0);
        chk("rst_we", 32'(bus.lb_we), 0);
        chk("rst_addr", 32'(bus.lb_addr), 0);
        chk("rst_data", 32'(bus.lb_data), 0);
        res = 0;

        // Plain tile
        clr();
        issue(5, 'h0C3, 'h20, 16, 0, 0, 3);
        wait_rdy(rc);
        chk("t1_nacc", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            chk("t1_acc0", acc_addr[0], a10);
            chk("t1_acc1", acc_addr[1], a11);
        end
        chk_tile("t1", t1a, t1d);
        if (wr_cyc.size() == 6 && acc_cyc.size() == 2) begin
            chk("t1_lat", wr_cyc[0] - acc_cyc[0], 3);
            chk("t1_done", rc - wr_cyc[5], 1);
        end

        // X-flipped tile
        clr();
        issue(5, 'h0C3, 'h20, 16, 0, 1, 3);
        wait_rdy(rc);
        chk("t2_nacc", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            chk("t2_acc0", acc_addr[0], a11);
            chk("t2_acc1", acc_addr[1], a10);
        end
        chk_tile("t2", t2a, t2d);

        // Right-edge clip and negative-X wrap
        data_mode = 1;
        clr();
        issue(0, 0, 0, 356, 0, 0, 5);
        wait_rdy(rc);
        chk("t3a_nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            chk("t3a_addr", wr_addr[i], 356 + i);
            chk("t3a_data", wr_data[i], 'h5F);
        end
        clr();
        issue(0, 0, 0, 508, 0, 0, 5);
        wait_rdy(rc);
        chk("t3b_nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr.size(); i++)
            chk("t3b_addr", wr_addr[i], i);

        // Wide sprite wrapping the column index, with random DRAM stalls
        data_mode = 2;
        stall_en = 1;
        clr();
        issue(60, 0, 0, 100, 7, 0, 2);
        wait_rdy(rc);
        chk("t4_nacc", acc_addr.size(), 16);
        for (int k = 0; k < 16 && k < acc_addr.size(); k++)
            chk("t4_acc", acc_addr[k], (120 + k) % 128);
        chk("t4_nwr", wr_addr.size(), 64);
        for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
            chk("t4_addr", wr_addr[i], 100 + i);
            chk("t4_data", wr_data[i], 'h20 | (((120 + i / 4) % 128) & 15) | 8);
        end
        stall_en = 0;

        // tsr_go while busy is ignored
        data_mode = 0;
        clr();
        issue(5, 'h0C3, 'h20, 16, 0, 0, 3);
        set_task(0, 0, 0, 200, 3, 1, 9);
        bus.tsr_go = 1;
        @(negedge clk);
        bus.tsr_go = 0;
        wait_rdy(rc);
        chk("t5a_nacc", acc_addr.size(), 2);
        chk_tile("t5a", t1a, t1d);

        // Back-to-back: new task in the first ready cycle
        clr();
        issue(5, 'h0C3, 'h20, 16, 0, 0, 3);
        wait_rdy(rc);
        set_task(5, 'h0C3, 'h20, 40, 0, 0, 3);
        bus.tsr_go = 1;
        clr();
        @(negedge clk);
        bus.tsr_go = 0;
        chk("t5b_rdy", 32'(bus.tsr_rdy), 0);
        chk("t5b_req", 32'(bus.dram_req), 1);
        wait_rdy(rc);
        chk_tile("t5b", b2a, t1d);

        // Reset mid-FETCH
        data_mode = 2;
        stall_en = 1;
        issue(60, 0, 0, 100, 7, 0, 2);
        repeat (3) @(negedge clk);
        res = 1;
        @(negedge clk);
        chk("t5c_rdy", 32'(bus.tsr_rdy), 1);
        chk("t5c_req", 32'(bus.dram_req), 0);
        chk("t5c_we", 32'(bus.lb_we), 0);
        res = 0;
        clr();
        repeat (10) @(negedge clk);
        chk("t5c_nacc", acc_addr.size(), 0);
        chk("t5c_nwr", wr_addr.size(), 0);
        stall_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
